// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_t;

    // Default number of MEM_WAIT cycles tolerated before a timeout
    localparam int MEM_TIMEOUT_DEF = 15;

    // Width of the wait-cycle counter used while a data access is outstanding
    localparam int WAIT_CNT_W = 8;

    // Width of the stall-cycle performance counter
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// rtl/hazard_ctrl_load_use_detect.sv - load-use comparator between the ID sources and the EX load target
module load_use_detect (
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       hit
);

    // x0 is never a real dependency, so a load targeting it is ignored
    always_comb begin
        hit = ex_memread && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/bubble sequencing for the five-stage core; HAZARD_PERF_EN builds stall_cnt
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_memread,
    input  logic                   ex_branch_taken,
    input  logic                   mem_req,
    input  logic                   dmem_ready,
    output logic                   dmem_valid,
    output logic                   pc_stall,
    output logic                   ifid_stall,
    output logic                   idex_stall,
    output logic                   exmem_stall,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   memwb_bubble,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

    hz_state_t             state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
    logic                  lu_hit;
    logic                  mem_stall;
    logic                  mem_valid;
    logic                  hz_ok;
    logic                  br_sel;
    logic                  lu_sel;

    load_use_detect u_load_use_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .hit        (lu_hit)
    );

    assign wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);

    // Mealy decode: memory stall first, hazards only in RUN when no memory stall is raised
    always_comb begin
        mem_stall = 1'b0;
        mem_valid = 1'b0;
        case (state)
            RUN: begin
                mem_valid = mem_req;
                mem_stall = mem_req && !dmem_ready;
            end
            MEM_WAIT: begin
                mem_valid = 1'b1;
                mem_stall = !dmem_ready;
            end
            ERR: begin
                mem_valid = 1'b0;
                mem_stall = 1'b1;
            end
            default: begin
                mem_valid = 1'b0;
                mem_stall = 1'b0;
            end
        endcase

        hz_ok  = (state == RUN) && !mem_stall;
        br_sel = hz_ok && ex_branch_taken;
        lu_sel = hz_ok && !ex_branch_taken && lu_hit;

        pc_stall     = mem_stall || lu_sel;
        ifid_stall   = mem_stall || lu_sel;
        idex_stall   = mem_stall;
        exmem_stall  = mem_stall;
        memwb_bubble = mem_stall;

        // A held register must keep its contents, so stall always beats flush
        ifid_flush = br_sel && !ifid_stall;
        idex_flush = (br_sel || lu_sel) && !idex_stall;

        // The request strobe drops as soon as reset is applied, without waiting for a clock
        dmem_valid = mem_valid && !rst_n;
    end

    // Memory handshake FSM with wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt_nxt == TIMEOUT_VAL) begin
                        state    <= ERR;
                        wait_cnt <= wait_cnt_nxt;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                    end
                end
                ERR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stall_cnt_q <= '0;
        end else if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken;
    logic        mem_req, dmem_ready;
    logic        dmem_valid, pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_flush, idex_flush, memwb_bubble, mem_err;
    logic [15:0] stall_cnt;
    logic [8:0]  outs;

    int checks = 0;
    int failures = 0;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {dmem_valid, pc, ifid, idex, exmem stalls, ifid_flush, idex_flush, memwb_bubble, mem_err}
    localparam logic [8:0] O_NONE  = 9'b0_0000_0000;
    localparam logic [8:0] O_LU    = 9'b0_1100_0100;
    localparam logic [8:0] O_BR    = 9'b0_0000_1100;
    localparam logic [8:0] O_DV    = 9'b1_0000_0000;
    localparam logic [8:0] O_MEMST = 9'b1_1111_0010;
    localparam logic [8:0] O_ERR   = 9'b0_1111_0011;

    always #5 clk = ~clk;

    assign outs = {dmem_valid, pc_stall, ifid_stall, idex_stall, exmem_stall,
                   ifid_flush, idex_flush, memwb_bubble, mem_err};

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .dmem_valid      (dmem_valid),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .idex_stall      (idex_stall),
        .exmem_stall     (exmem_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_bubble    (memwb_bubble),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt_exp(input int v);
        return PERF ? 16'(v) : 16'h0000;
    endfunction

    // Check the output vector mid-cycle, then advance to just after the next rising edge
    task automatic cyc(input string tag, input logic [8:0] exp);
        @(negedge clk);
        chk(tag, {7'd0, outs}, {7'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic cnt_chk(input string tag, input int v);
        chk(tag, stall_cnt, cnt_exp(v));
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0; ex_branch_taken = 0;
        mem_req = 0; dmem_ready = 0;
    endtask

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        cyc("reset_outs", O_NONE);
        cnt_chk("reset_cnt", 0);
        rst_n = 1'b0;

        cyc("idle", O_NONE);

        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        cyc("lu_rs1", O_LU);
        ex_memread = 0;
        cyc("lu_one_bubble", O_NONE);
        cnt_chk("cnt_after_lu", 1);

        ex_memread = 1; ex_rd = 0; id_rs1 = 0;
        cyc("lu_x0", O_NONE);

        ex_rd = 7; id_rs1 = 5; id_rs2 = 7; id_use_rs2 = 0;
        cyc("lu_rs2_unused", O_NONE);
        id_use_rs2 = 1;
        cyc("lu_rs2", O_LU);

        ex_branch_taken = 1;
        cyc("branch_over_lu", O_BR);
        clear_inputs();
        cyc("after_branch", O_NONE);
        cnt_chk("cnt_after_branch", 2);

        mem_req = 1; dmem_ready = 1;
        cyc("zero_wait", O_DV);
        clear_inputs();
        cyc("zero_wait_done", O_NONE);

        mem_req = 1; dmem_ready = 0;
        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        cyc("mem_w1_masks_lu", O_MEMST);
        cyc("mem_w2", O_MEMST);
        cyc("mem_w3", O_MEMST);
        dmem_ready = 1;
        cyc("mem_release", O_DV);
        cnt_chk("cnt_mem3", 5);
        mem_req = 0; dmem_ready = 0;
        cyc("lu_reevaluated", O_LU);
        clear_inputs();
        cyc("mem_done", O_NONE);
        cnt_chk("cnt_after_reeval", 6);

        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) cyc("edge_wait", O_MEMST);
        dmem_ready = 1;
        cyc("edge_release", O_DV);
        clear_inputs();
        cyc("edge_no_err", O_NONE);

        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) cyc("to_wait", O_MEMST);
        cyc("to_err", O_ERR);
        cnt_chk("cnt_err", 16);
        dmem_ready = 1; ex_branch_taken = 1;
        cyc("err_sticky", O_ERR);

        ex_branch_taken = 0;
        #1;
        rst_n = 1'b1;
        #1;
        chk("async_rst_outs", {7'd0, outs}, {7'd0, O_NONE});
        cnt_chk("async_rst_cnt", 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        cyc("post_reset", O_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
